// File: rtl/addr_req_queue_if.sv
// Valid/ready address bundle between trace source and the cache request queue.
// master drives requests in and consumes the head; slave is the queue side.
interface addr_req_queue_if #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 7
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W-1:0]   in_addr;
    logic                out_valid;
    logic                out_ready;
    logic [ADDR_W-1:0]   out_addr;
    logic [TAG_W-1:0]    out_tag;
    logic [INDEX_W-1:0]  out_index;
    logic [OFFSET_W-1:0] out_offset;

    modport master (
        output in_valid, in_addr, out_ready,
        input  in_ready, out_valid, out_addr,
        input  out_tag, out_index, out_offset
    );

    modport slave (
        input  in_valid, in_addr, out_ready,
        output in_ready, out_valid, out_addr,
        output out_tag, out_index, out_offset
    );
endinterface

// File: rtl/addr_req_queue.sv
// FWFT address request queue with tag/index/offset split and request counters.
// Define ADDR_COALESCE_EN to drop back-to-back requests to the same cache block.
module addr_req_queue #(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 16,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 7
) (
    input  logic                     clock,
    input  logic                     reset_n,
    addr_req_queue_if.slave          bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              req_total,
    output logic [31:0]              coal_total
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [31:0]       req_q, req_d;
    logic              empty, full;
    logic              push, pop, wr_en, coal_hit;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0])
                && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign push  = bus.in_valid & bus.in_ready;
    assign pop   = bus.out_valid & bus.out_ready;
    assign wr_en = push & ~coal_hit;

    assign bus.out_addr   = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.out_tag    = bus.out_addr[ADDR_W-1 -: TAG_W];
    assign bus.out_index  = bus.out_addr[OFFSET_W +: INDEX_W];
    assign bus.out_offset = bus.out_addr[OFFSET_W-1:0];

    assign count     = wr_ptr_q - rd_ptr_q;
    assign req_total = req_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        req_d    = req_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && req_q != 32'hFFFF_FFFF) req_d = req_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            req_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            req_q    <= req_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.in_addr;
    end

`ifdef ADDR_COALESCE_EN
    localparam int BLK_W = ADDR_W - OFFSET_W;

    logic [BLK_W-1:0] last_blk_q, last_blk_d;
    logic             last_vld_q, last_vld_d;
    logic [31:0]      coal_q, coal_d;

    assign coal_hit = last_vld_q
                   && (bus.in_addr[ADDR_W-1:OFFSET_W] == last_blk_q);

    always_comb begin
        last_blk_d = last_blk_q;
        last_vld_d = last_vld_q;
        coal_d     = coal_q;
        if (push) begin
            last_blk_d = bus.in_addr[ADDR_W-1:OFFSET_W];
            last_vld_d = 1'b1;
            if (coal_hit && coal_q != 32'hFFFF_FFFF) coal_d = coal_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_blk_q <= '0;
            last_vld_q <= 1'b0;
            coal_q     <= '0;
        end else begin
            last_blk_q <= last_blk_d;
            last_vld_q <= last_vld_d;
            coal_q     <= coal_d;
        end
    end

    assign coal_total = coal_q;
`else
    assign coal_hit   = 1'b0;
    assign coal_total = '0;
`endif
endmodule

// File: tb/tb_addr_req_queue.sv
// Scoreboard bench for addr_req_queue: stimulus queues expected heads,
// a negedge monitor pops and checks every dequeued entry.
module tb_addr_req_queue;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  count;
    logic [31:0] req_total;
    logic [31:0] coal_total;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];

    addr_req_queue_if #(.ADDR_W(32), .OFFSET_W(6), .INDEX_W(7)) bus ();

    addr_req_queue #(
        .ADDR_W(32), .DEPTH(16), .OFFSET_W(6), .INDEX_W(7)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .count      (count),
        .req_total  (req_total),
        .coal_total (coal_total)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Field expectations use shifts/masks: tag = a>>13, index = (a>>6)&7F.
    always @(negedge clock) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", bus.out_addr, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_addr",   bus.out_addr,           e);
                check("sb_tag",    32'(bus.out_tag),       e >> 13);
                check("sb_index",  32'(bus.out_index),     (e >> 6) & 32'h7F);
                check("sb_offset", 32'(bus.out_offset),    e & 32'h3F);
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Present one address; queue it as expected when accepted and written.
    task automatic drive(input logic [31:0] a, input bit wr);
        bit ok;
        ok = 1'b0;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                ok = 1'b1;
                if (wr) exp_q.push_back(a);
                break;
            end
        end
        if (!ok) check("push_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (count == 5'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'(count), 32'd0);
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_count",     32'(count),         32'd0);
        check("rst_req",       req_total,          32'd0);
        check("rst_coal",      coal_total,         32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: single push, fields of 0x1040 = tag 0, index 0x41, offset 0
        drive(32'h0000_1040, 1'b1);
        @(negedge clock);
        check("t1_out_valid", 32'(bus.out_valid),  32'd1);
        check("t1_count",     32'(count),          32'd1);
        check("t1_req",       req_total,           32'd1);
        check("t1_tag",       32'(bus.out_tag),    32'h0);
        check("t1_index",     32'(bus.out_index),  32'h41);
        check("t1_offset",    32'(bus.out_offset), 32'h0);
        drain();

        // 2: fill to 16, then a 17th request must stall
        do_reset();
        for (int i = 0; i < 16; i++)
            drive(32'h0000_2000 + 32'(i) * 32'h40, 1'b1);
        @(negedge clock);
        check("t2_in_ready", 32'(bus.in_ready), 32'd0);
        check("t2_count",    32'(count),        32'd16);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h9999_0000;
        repeat (3) @(negedge clock);
        check("t2_17_req",   req_total,   32'd16);
        check("t2_17_count", 32'(count),  32'd16);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;

        // 3: push+pop while full: only the pop happens
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_addr   = 32'h8888_0000;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("t3_ready_full", 32'(bus.in_ready), 32'd0);
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clock);
        check("t3_count",    32'(count),        32'd15);
        check("t3_in_ready", 32'(bus.in_ready), 32'd1);
        check("t3_req",      req_total,         32'd16);
        drain();

        // 4: 40-deep stream with push and pop every cycle
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 32'h0010_0000 + 32'(i) * 32'h40;
            @(negedge clock);
            if (bus.in_ready) exp_q.push_back(bus.in_addr);
            else check("t4_in_ready", 32'd0, 32'd1);
            if (i > 0) check("t4_count", 32'(count), 32'd1);
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        drain();
        check("t4_req", req_total, 32'd56);

        // 5: reset mid-stream with 7 held
        for (int i = 0; i < 7; i++)
            drive(32'h0000_5000 + 32'(i) * 32'h40, 1'b1);
        @(negedge clock);
        check("t5_count7", 32'(count), 32'd7);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_count", 32'(count),         32'd0);
        check("t5_rst_ready", 32'(bus.in_ready),  32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        drive(32'h0000_7000, 1'b1);
        @(negedge clock);
        check("t5_alone", 32'(count), 32'd1);
        drain();

        // 6: same-block run 0x100,0x104,0x13C then new block 0x140
        do_reset();
`ifdef ADDR_COALESCE_EN
        drive(32'h100, 1'b1);
        drive(32'h104, 1'b0);
        drive(32'h13C, 1'b0);
        drive(32'h140, 1'b1);
        @(negedge clock);
        check("t6_count", 32'(count), 32'd2);
        check("t6_coal",  coal_total, 32'd2);
`else
        drive(32'h100, 1'b1);
        drive(32'h104, 1'b1);
        drive(32'h13C, 1'b1);
        drive(32'h140, 1'b1);
        @(negedge clock);
        check("t6_count", 32'(count), 32'd4);
        check("t6_coal",  coal_total, 32'd0);
`endif
        check("t6_req", req_total, 32'd4);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
